exe_muldiv_unit: RTL and testbench

// - EXE-stage multiply/divide unit. Consumes the aluop/src1/src2 fields

---
 rtl/exe_muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_unit.sv
// EXE-stage multiply/divide unit: single-cycle MULT/MULTU and a 32-iteration
// radix-2 restoring divider for DIV/DIVU that stalls the front of the pipeline.
module exe_muldiv_unit #(
  parameter int unsigned        ALUOP_W  = 8,
  parameter logic [ALUOP_W-1:0] OP_MULT  = 8'h14,
  parameter logic [ALUOP_W-1:0] OP_MULTU = 8'h15,
  parameter logic [ALUOP_W-1:0] OP_DIV   = 8'h16,
  parameter logic [ALUOP_W-1:0] OP_DIVU  = 8'h17
) (
  input  logic               i_cpu_clk_50M,
  input  logic               i_cpu_rst,
  input  logic [ALUOP_W-1:0] i_exe_aluop,
  input  logic [31:0]        i_exe_src1,
  input  logic [31:0]        i_exe_src2,
  input  logic               i_exe_stall,
  input  logic               i_flush,
  output logic               o_stallreq_exe,
  output logic [31:0]        o_muldiv_hi,
  output logic [31:0]        o_muldiv_lo,
  output logic               o_muldiv_whilo,
  output logic               o_div_busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_live;
  logic [5:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic        r_q_neg;
  logic        r_r_neg;

  logic        w_is_mult;
  logic        w_is_multu;
  logic        w_is_div;
  logic        w_div_op;
  logic        w_launch;
  logic        w_src1_neg;
  logic        w_src2_neg;
  logic        w_div_zero;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_is_mult  = (i_exe_aluop == OP_MULT);
  assign w_is_multu = (i_exe_aluop == OP_MULTU);
  assign w_is_div   = (i_exe_aluop == OP_DIV);
  assign w_div_op   = w_is_div | (i_exe_aluop == OP_DIVU);

  // r_live masks the first cycle after reset release so outputs stay at zero.
  assign w_launch   = r_live & (r_state == StIdle) & w_div_op & ~i_flush;
  assign w_src1_neg = w_is_div & i_exe_src1[31];
  assign w_src2_neg = w_is_div & i_exe_src2[31];
  assign w_div_zero = (i_exe_src2 == 32'd0);
  assign w_abs1     = w_src1_neg ? (32'd0 - i_exe_src1) : i_exe_src1;
  assign w_abs2     = w_src2_neg ? (32'd0 - i_exe_src2) : i_exe_src2;

  // Remainder is always below the divisor, so the difference fits in 32 bits when w_ge.
  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_divisor});
  assign w_diff  = w_shift[31:0] - r_divisor;

  assign w_prod_s = 64'($signed(i_exe_src1)) * 64'($signed(i_exe_src2));
  assign w_prod_u = {32'd0, i_exe_src1} * {32'd0, i_exe_src2};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_launch) w_state_nxt = w_div_zero ? StDone : StBusy;
      StBusy:  if (r_cnt == 6'd31) w_state_nxt = StDone;
      StDone:  if (!i_exe_stall) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (i_flush) w_state_nxt = StIdle;
  end

  always_ff @(posedge i_cpu_clk_50M or posedge i_cpu_rst) begin
    if (i_cpu_rst) begin
      r_state   <= StIdle;
      r_live    <= 1'b0;
      r_cnt     <= 6'd0;
      r_rem     <= 32'd0;
      r_quo     <= 32'd0;
      r_divisor <= 32'd0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_nxt;
      if (i_flush) begin
        r_cnt <= 6'd0;
      end else if (w_launch) begin
        r_cnt <= 6'd0;
        if (w_div_zero) begin
          // Preload the divide-by-zero result; DONE then presents it unsigned.
          r_quo     <= 32'hFFFF_FFFF;
          r_rem     <= i_exe_src1;
          r_divisor <= 32'd0;
          r_q_neg   <= 1'b0;
          r_r_neg   <= 1'b0;
        end else begin
          r_quo     <= w_abs1;
          r_rem     <= 32'd0;
          r_divisor <= w_abs2;
          r_q_neg   <= w_src1_neg ^ w_src2_neg;
          r_r_neg   <= w_src1_neg;
        end
      end else if (r_state == StBusy) begin
        r_rem <= w_ge ? w_diff : w_shift[31:0];
        r_quo <= {r_quo[30:0], w_ge};
        r_cnt <= r_cnt + 6'd1;
      end
    end
  end

  always_comb begin
    o_stallreq_exe = 1'b0;
    o_muldiv_hi    = 32'd0;
    o_muldiv_lo    = 32'd0;
    o_muldiv_whilo = 1'b0;
    o_div_busy     = 1'b0;
    if (r_live && !i_flush) begin
      case (r_state)
        StIdle: begin
          o_stallreq_exe = w_div_op;
          if (w_is_mult) begin
            {o_muldiv_hi, o_muldiv_lo} = w_prod_s;
            o_muldiv_whilo             = 1'b1;
          end else if (w_is_multu) begin
            {o_muldiv_hi, o_muldiv_lo} = w_prod_u;
            o_muldiv_whilo             = 1'b1;
          end
        end
        StBusy: begin
          o_stallreq_exe = 1'b1;
          o_div_busy     = 1'b1;
        end
        StDone: begin
          o_div_busy     = 1'b1;
          o_muldiv_whilo = 1'b1;
          o_muldiv_lo    = r_q_neg ? (32'd0 - r_quo) : r_quo;
          o_muldiv_hi    = r_r_neg ? (32'd0 - r_rem) : r_rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Directed-vector bench for exe_muldiv_unit with hand-computed expected results.
module tb_exe_muldiv_unit;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MULT  = 8'h14;
  localparam logic [7:0] OP_MULTU = 8'h15;
  localparam logic [7:0] OP_DIV   = 8'h16;
  localparam logic [7:0] OP_DIVU  = 8'h17;

  logic        clk;
  logic        rst;
  logic [7:0]  aluop;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        exe_stall;
  logic        flush;
  logic        stallreq;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        whilo;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;

  exe_muldiv_unit u_dut (
    .i_cpu_clk_50M (clk),
    .i_cpu_rst     (rst),
    .i_exe_aluop   (aluop),
    .i_exe_src1    (src1),
    .i_exe_src2    (src2),
    .i_exe_stall   (exe_stall),
    .i_flush       (flush),
    .o_stallreq_exe(stallreq),
    .o_muldiv_hi   (hi),
    .o_muldiv_lo   (lo),
    .o_muldiv_whilo(whilo),
    .o_div_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_stall, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int hold);
    int n;
    int early_whilo;
    aluop = op;
    src1  = a;
    src2  = b;
    #1;
    n = 0;
    early_whilo = 0;
    while (stallreq && n < 40) begin
      if (whilo) early_whilo++;
      n++;
      @(posedge clk);
      #2;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, "_early_whilo"}, 32'(early_whilo), 32'd0);
    chk({tag, "_whilo"}, {31'd0, whilo}, 32'd1);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_hi"}, hi, exp_hi);
    exe_stall = (hold > 0);
    for (int k = 1; k <= hold; k++) begin
      tick();
      #1;
      chk({tag, "_hold_lo"}, lo, exp_lo);
      chk({tag, "_hold_hi"}, hi, exp_hi);
      chk({tag, "_hold_ctl"}, {29'd0, stallreq, whilo, busy}, 32'b011);
      exe_stall = (k < hold);
    end
    tick();
    aluop = OP_NOP;
    #1;
    chk({tag, "_idle"}, {29'd0, stallreq, whilo, busy}, 32'b000);
  endtask

  initial begin
    int n_bad;
    rst       = 1'b1;
    aluop     = OP_MULT;
    src1      = 32'd3;
    src2      = 32'd5;
    exe_stall = 1'b0;
    flush     = 1'b0;

    // Outputs masked during reset and in the first cycle after release.
    repeat (2) tick();
    #1;
    chk("rst_lo", lo, 32'd0);
    chk("rst_ctl", {29'd0, stallreq, whilo, busy}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_lo", lo, 32'd0);
    chk("rel_whilo", {31'd0, whilo}, 32'd0);
    tick();
    #1;
    chk("mult_3x5_lo", lo, 32'd15);
    chk("mult_3x5_hi", hi, 32'd0);
    chk("mult_3x5_whilo", {31'd0, whilo}, 32'd1);

    aluop = OP_MULT;  src1 = 32'hFFFF_FFFD;  src2 = 32'd5;
    #1;
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
    chk("mult_neg_stall", {31'd0, stallreq}, 32'd0);
    aluop = OP_MULTU;  src1 = 32'hFFFF_FFFF;  src2 = 32'd2;
    #1;
    chk("multu_hi", hi, 32'd1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    aluop = OP_NOP;
    #1;
    chk("nop_out", {hi[0], lo[0], whilo}, 3'b000);
    chk("nop_lo", lo, 32'd0);

    tick();
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2, 0);
    tick();
    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    tick();
    run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1, 0);
    tick();
    run_div("div_wrap", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 0);
    tick();
    run_div("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0, 0);
    tick();
    run_div("divu_dbz", OP_DIVU, 32'h1234, 32'd0, 1, 32'hFFFF_FFFF, 32'h1234, 0);
    tick();
    run_div("div_dbz", OP_DIV, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 0);

    // Flush in the 10th busy cycle discards DIVU 1000/3.
    tick();
    aluop = OP_DIVU;  src1 = 32'd1000;  src2 = 32'd3;
    n_bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!stallreq || whilo) n_bad++;
      tick();
    end
    flush = 1'b1;
    #1;
    chk("flush_busy_bad", 32'(n_bad), 32'd0);
    chk("flush_ctl", {29'd0, stallreq, whilo, busy}, 32'd0);
    tick();
    flush = 1'b0;
    aluop = OP_NOP;
    #1;
    chk("post_flush_ctl", {29'd0, stallreq, whilo, busy}, 32'd0);
    tick();
    run_div("divu_9_4", OP_DIVU, 32'd9, 32'd4, 33, 32'd2, 32'd1, 0);
    tick();
    run_div("divu_9_4_hold", OP_DIVU, 32'd9, 32'd4, 33, 32'd2, 32'd1, 3);

    // Asynchronous reset in the middle of a division.
    tick();
    aluop = OP_DIVU;  src1 = 32'd50;  src2 = 32'd5;
    repeat (5) tick();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {29'd0, stallreq, whilo, busy}, 32'd0);
    tick();
    rst   = 1'b0;
    aluop = OP_NOP;
    tick();
    #1;
    chk("rst_mid_after", {29'd0, stallreq, whilo, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
